// File: rtl/alu_issue.sv
// alu_issue: single-entry decode/issue register between fetch and the ALU.
// Define ALU_ISSUE_FWD_EN to add the write-back bypass ports (wb_wen/wb_addr/wb_data).
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif

module alu_issue #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [31:0]              in_pc,
  output logic [REG_ADDR_W-1:0]    rs1_addr,
  output logic [REG_ADDR_W-1:0]    rs2_addr,
  input  logic [`CPU_WIDTH-1:0]    rs1_data,
  input  logic [`CPU_WIDTH-1:0]    rs2_data,
  input  logic                     flush,
`ifdef ALU_ISSUE_FWD_EN
  input  logic                     wb_wen,
  input  logic [REG_ADDR_W-1:0]    wb_addr,
  input  logic [`CPU_WIDTH-1:0]    wb_data,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [`ALU_OP_WIDTH-1:0] alu_op,
  output logic [`CPU_WIDTH-1:0]    alu_src1,
  output logic [`CPU_WIDTH-1:0]    alu_src2,
  output logic [REG_ADDR_W-1:0]    rd_addr,
  output logic                     rd_wen,
  output logic                     is_branch,
  output logic [31:0]              branch_target,
  output logic                     illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [REG_ADDR_W-1:0]   rd_field;
  logic [`CPU_WIDTH-1:0]   opnd1;
  logic [`CPU_WIDTH-1:0]   opnd2;
  logic [31:0]             imm_i;
  logic [31:0]             imm_u;
  logic [31:0]             imm_b;
  logic                    load;

  logic [`ALU_OP_WIDTH-1:0] dec_op;
  logic [`CPU_WIDTH-1:0]    dec_src1;
  logic [`CPU_WIDTH-1:0]    dec_src2;
  logic [REG_ADDR_W-1:0]    dec_rd;
  logic                     dec_wen;
  logic                     dec_br;
  logic [31:0]              dec_tgt;
  logic                     dec_ill;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rd_field = REG_ADDR_W'(in_inst[11:7]);
  assign rs1_addr = REG_ADDR_W'(in_inst[19:15]);
  assign rs2_addr = REG_ADDR_W'(in_inst[24:20]);

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};

  // x0 reads as zero; bypass only applies to real registers.
  always_comb begin
    opnd1 = rs1_data;
    opnd2 = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
    if (wb_wen && wb_addr != '0 && wb_addr == rs1_addr) opnd1 = wb_data;
    if (wb_wen && wb_addr != '0 && wb_addr == rs2_addr) opnd2 = wb_data;
`endif
    if (rs1_addr == '0) opnd1 = '0;
    if (rs2_addr == '0) opnd2 = '0;
  end

  always_comb begin
    dec_op   = `ALU_ADD;
    dec_src1 = '0;
    dec_src2 = '0;
    dec_rd   = '0;
    dec_wen  = 1'b0;
    dec_br   = 1'b0;
    dec_tgt  = '0;
    dec_ill  = 1'b0;
    if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == 7'b0000000) begin
      dec_src1 = opnd1;
      dec_src2 = opnd2;
      dec_rd   = rd_field;
      dec_wen  = 1'b1;
    end else if (opcode == OPC_OP && funct3 == 3'b000 && funct7 == 7'b0100000) begin
      dec_op   = `ALU_SUB;
      dec_src1 = opnd1;
      dec_src2 = opnd2;
      dec_rd   = rd_field;
      dec_wen  = 1'b1;
    end else if (opcode == OPC_OP_IMM && funct3 == 3'b000) begin
      dec_src1 = opnd1;
      dec_src2 = `CPU_WIDTH'(imm_i);
      dec_rd   = rd_field;
      dec_wen  = 1'b1;
    end else if (opcode == OPC_LUI) begin
      dec_src2 = `CPU_WIDTH'(imm_u);
      dec_rd   = rd_field;
      dec_wen  = 1'b1;
    end else if (opcode == OPC_AUIPC) begin
      dec_src1 = `CPU_WIDTH'(in_pc);
      dec_src2 = `CPU_WIDTH'(imm_u);
      dec_rd   = rd_field;
      dec_wen  = 1'b1;
    end else if (opcode == OPC_BRANCH && funct3 == 3'b000) begin
      dec_op   = `ALU_SUB;
      dec_src1 = opnd1;
      dec_src2 = opnd2;
      dec_br   = 1'b1;
      dec_tgt  = in_pc + imm_b;
    end else begin
      dec_ill  = 1'b1;
    end
    if (dec_rd == '0) dec_wen = 1'b0;
  end

  assign in_ready = !flush && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_op        <= `ALU_ADD;
      alu_src1      <= '0;
      alu_src2      <= '0;
      rd_addr       <= '0;
      rd_wen        <= 1'b0;
      is_branch     <= 1'b0;
      branch_target <= '0;
      illegal       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      alu_op        <= dec_op;
      alu_src1      <= dec_src1;
      alu_src2      <= dec_src2;
      rd_addr       <= dec_rd;
      rd_wen        <= dec_wen;
      is_branch     <= dec_br;
      branch_target <= dec_tgt;
      illegal       <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vector table, handshake corner sequences and a
// randomized scoreboard run against a behavioural RV32I-subset decoder.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif

module tb_alu_issue;
  typedef logic [`ALU_OP_WIDTH-1:0] op_t;
  typedef struct packed {
    op_t         op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  rd;
    logic        wen;
    logic        br;
    logic [31:0] tgt;
    logic        ill;
  } res_t;
  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  op_t         alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic        is_branch;
  logic [31:0] branch_target;
  logic        illegal;
`ifdef ALU_ISSUE_FWD_EN
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`endif

  logic [31:0] regs [32];
  int          checks = 0;
  int          fails  = 0;
  res_t        q[$];
  vec_t        vecs[$];

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  always #5 clk = ~clk;

  alu_issue #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush),
`ifdef ALU_ISSUE_FWD_EN
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .is_branch(is_branch),
    .branch_target(branch_target), .illegal(illegal)
  );

  function automatic res_t mk(op_t op, logic [31:0] s1, logic [31:0] s2, logic [4:0] rd,
                              logic wen, logic br, logic [31:0] tgt, logic ill);
    res_t r;
    r.op = op; r.s1 = s1; r.s2 = s2; r.rd = rd;
    r.wen = wen; r.br = br; r.tgt = tgt; r.ill = ill;
    return r;
  endfunction

  function automatic vec_t mkv(string name, logic [31:0] inst, logic [31:0] pc, res_t exp);
    vec_t v;
    v.name = name; v.inst = inst; v.pc = pc; v.exp = exp;
    return v;
  endfunction

  function automatic res_t actual();
    return mk(alu_op, alu_src1, alu_src2, rd_addr, rd_wen, is_branch, branch_target, illegal);
  endfunction

  // Register value seen by the instruction being decoded this cycle.
  function automatic logic [31:0] reg_val(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef ALU_ISSUE_FWD_EN
    if (wb_wen && wb_addr == a) return wb_data;
`endif
    return regs[a];
  endfunction

  function automatic res_t model(logic [31:0] inst, logic [31:0] pc);
    res_t        r;
    int          imm12;
    logic [12:0] boff;
    int          boff_int;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    r = mk(`ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    if (opc == 7'h33 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) begin
      r.op = (f7 == 7'h20) ? `ALU_SUB : `ALU_ADD;
      r.s1 = reg_val(inst[19:15]);
      r.s2 = reg_val(inst[24:20]);
      r.rd = inst[11:7];
    end else if (opc == 7'h13 && f3 == 3'd0) begin
      imm12 = $signed(inst[31:20]);
      r.s1 = reg_val(inst[19:15]);
      r.s2 = 32'(imm12);
      r.rd = inst[11:7];
    end else if (opc == 7'h37 || opc == 7'h17) begin
      r.s1 = (opc == 7'h17) ? pc : 32'd0;
      r.s2 = inst & 32'hFFFF_F000;
      r.rd = inst[11:7];
    end else if (opc == 7'h63 && f3 == 3'd0) begin
      boff     = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      boff_int = $signed(boff);
      r.op  = `ALU_SUB;
      r.s1  = reg_val(inst[19:15]);
      r.s2  = reg_val(inst[24:20]);
      r.br  = 1'b1;
      r.tgt = 32'(longint'(pc) + longint'(boff_int));
    end else begin
      r.ill = 1'b1;
    end
    r.wen = !r.ill && !r.br && (r.rd != 5'd0);
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = $urandom;
    case ($urandom_range(0, 6))
      0: return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
      1: return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
      2: return {imm[11:0], rs1, 3'd0, rd, 7'h13};
      3: return {imm[19:0], rd, 7'h37};
      4: return {imm[19:0], rd, 7'h17};
      5: return {imm[6:0], rs2, rs1, 3'd0, imm[11:7], 7'h63};
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(string name, logic exp_valid, res_t exp, logic cmp_fields);
    checks++;
    if (out_valid !== exp_valid || (cmp_fields && actual() !== exp)) begin
      fails++;
      $display("FAIL %s: got valid=%0b fields=%h, expected valid=%0b fields=%h",
               name, out_valid, actual(), exp_valid, exp);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  localparam logic [31:0] I_ADD  = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] I_SUB  = 32'h4011_0333;  // sub  x6,x2,x1
  localparam logic [31:0] I_BEQ  = 32'hFE20_8CE3;  // beq  x1,x2,-8

  res_t rst_val;
  res_t held;
  logic exp_rdy;

  initial begin
    rst_val = mk(`ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    foreach (regs[i]) regs[i] = 32'd0;
    regs[0] = 32'hDEAD_BEEF;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
    wb_wen = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
`endif

    // Reset state
    #12;
    check_out("reset_state", 1'b0, rst_val, 1'b1);
    #1 rst_n = 1'b1;
    tick();
    check_bit("ready_after_reset", in_ready, 1'b1);
    check_out("idle_after_reset", 1'b0, rst_val, 1'b1);

    // Directed decode table
    vecs.push_back(mkv("add",      I_ADD,         32'h0,   mk(`ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0)));
    vecs.push_back(mkv("sub",      I_SUB,         32'h0,   mk(`ALU_SUB, 32'd7, 32'd5, 5'd6, 1'b1, 1'b0, 32'd0, 1'b0)));
    vecs.push_back(mkv("addi_m1",  32'hFFF0_0213, 32'h0,   mk(`ALU_ADD, 32'd0, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0, 32'd0, 1'b0)));
    vecs.push_back(mkv("lui",      32'h1234_52B7, 32'h0,   mk(`ALU_ADD, 32'd0, 32'h1234_5000, 5'd5, 1'b1, 1'b0, 32'd0, 1'b0)));
    vecs.push_back(mkv("auipc",    32'h0000_1397, 32'h200, mk(`ALU_ADD, 32'h200, 32'h1000, 5'd7, 1'b1, 1'b0, 32'd0, 1'b0)));
    vecs.push_back(mkv("beq_m8",   I_BEQ,         32'h100, mk(`ALU_SUB, 32'd5, 32'd7, 5'd0, 1'b0, 1'b1, 32'hF8, 1'b0)));
    vecs.push_back(mkv("beq_wrap", I_BEQ,         32'h4,   mk(`ALU_SUB, 32'd5, 32'd7, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0)));
    vecs.push_back(mkv("add_rd0",  32'h0020_8033, 32'h0,   mk(`ALU_ADD, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0)));
    vecs.push_back(mkv("add_rs0",  32'h0020_0433, 32'h0,   mk(`ALU_ADD, 32'd0, 32'd7, 5'd8, 1'b1, 1'b0, 32'd0, 1'b0)));
    vecs.push_back(mkv("illegal",  32'hFFFF_FFFF, 32'h0,   mk(`ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1)));
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
      tick();
      check_out(vecs[i].name, 1'b1, vecs[i].exp, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check_out("drain_empty", 1'b0, rst_val, 1'b0);

    // Backpressure: three stalled cycles, then back-to-back resume
    held = mk(`ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0);
    in_valid = 1'b1; in_inst = I_ADD; in_pc = 32'h0;
    tick();
    in_inst = I_SUB; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check_bit("stall_in_ready", in_ready, 1'b0);
      tick();
      check_out("stall_hold", 1'b1, held, 1'b1);
    end
    out_ready = 1'b1;
    #1 check_bit("resume_in_ready", in_ready, 1'b1);
    tick();
    check_out("resume_next", 1'b1, mk(`ALU_SUB, 32'd7, 32'd5, 5'd6, 1'b1, 1'b0, 32'd0, 1'b0), 1'b1);
    in_valid = 1'b0;
    tick();
    check_out("resume_no_dup", 1'b0, rst_val, 1'b0);

    // Flush beats a pending load and a held entry
    in_valid = 1'b1; in_inst = I_ADD;
    tick();
    check_out("pre_flush", 1'b1, held, 1'b1);
    flush = 1'b1; out_ready = 1'b0; in_inst = I_SUB;
    #1 check_bit("flush_in_ready", in_ready, 1'b0);
    tick();
    check_out("flush_clears", 1'b0, rst_val, 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_out("flush_dropped_input", 1'b0, rst_val, 1'b0);

    // Asynchronous reset mid-transfer
    in_valid = 1'b1; in_inst = I_ADD;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 1'b0, rst_val, 1'b1);
    #2 rst_n = 1'b1;
    tick();
    check_out("reset_no_output", 1'b0, rst_val, 1'b0);

`ifdef ALU_ISSUE_FWD_EN
    // Write-back bypass
    regs[1] = 32'h11; regs[2] = 32'd7; out_ready = 1'b1;
    wb_wen = 1'b1; wb_addr = 5'd1; wb_data = 32'hAA;
    in_valid = 1'b1; in_inst = I_ADD;
    tick();
    check_out("fwd_hit", 1'b1, mk(`ALU_ADD, 32'hAA, 32'd7, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0), 1'b1);
    wb_addr = 5'd0;
    tick();
    check_out("fwd_x0", 1'b1, mk(`ALU_ADD, 32'h11, 32'd7, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0), 1'b1);
    in_valid = 1'b0; wb_wen = 1'b0;
    tick();
`endif

    // Randomized traffic against the scoreboard
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    regs[0] = $urandom | 32'h1;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (q.size() > 0) check_out("rand_out", 1'b1, q[0], 1'b1);
      else              check_out("rand_idle", 1'b0, rst_val, 1'b0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
`ifdef ALU_ISSUE_FWD_EN
      wb_wen  = $urandom_range(0, 1) != 0;
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
`endif
      #1;
      exp_rdy = !flush && (q.size() == 0 || out_ready);
      check_bit("rand_in_ready", in_ready, exp_rdy);
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back(model(in_inst, in_pc));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
